// File: rtl/uart_rx_oversampled.sv
// 8N1-style UART receiver oversampled at 16x baud; samples each bit at its midpoint
// and presents the assembled word with a one-cycle done strobe and a frame-error flag.
`timescale 1ns/1ps
module uart_rx_oversampled #(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            s_tick,
   output logic [DBIT-1:0] rx_dout,
   output logic            rx_done_tick,
   output logic            frame_err
);

   localparam int unsigned SW = (SB_TICK > 16) ? 5 : 4;
   localparam int unsigned NW = $clog2(DBIT);

   localparam logic [SW-1:0] START_MID = SW'(7);
   localparam logic [SW-1:0] DATA_LAST = SW'(15);
   localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } state_t;

   logic            r_rx_meta;
   logic            r_rx_s;
   state_t          r_state;
   logic [SW-1:0]   r_s_cnt;
   logic [NW-1:0]   r_n_cnt;
   logic [DBIT-1:0] r_shift;
   logic [DBIT-1:0] r_dout;
   logic            r_done;
   logic            r_ferr;

   state_t          w_state_nx;
   logic [SW-1:0]   w_s_cnt_nx;
   logic [NW-1:0]   w_n_cnt_nx;
   logic [DBIT-1:0] w_shift_nx;
   logic [DBIT-1:0] w_dout_nx;
   logic            w_done_nx;
   logic            w_ferr_nx;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_state   <= IDLE;
         r_s_cnt   <= '0;
         r_n_cnt   <= '0;
         r_shift   <= '0;
         r_dout    <= '0;
         r_done    <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
         r_state   <= w_state_nx;
         r_s_cnt   <= w_s_cnt_nx;
         r_n_cnt   <= w_n_cnt_nx;
         r_shift   <= w_shift_nx;
         r_dout    <= w_dout_nx;
         r_done    <= w_done_nx;
         r_ferr    <= w_ferr_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_s_cnt_nx = r_s_cnt;
      w_n_cnt_nx = r_n_cnt;
      w_shift_nx = r_shift;
      w_dout_nx  = r_dout;
      w_done_nx  = 1'b0;
      w_ferr_nx  = r_ferr;
      case (r_state)
         IDLE: begin
            // Start detection needs no tick, so a line still low after a bad stop restarts at once.
            if (!r_rx_s) begin
               w_state_nx = START;
               w_s_cnt_nx = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (r_s_cnt == START_MID) begin
                  if (!r_rx_s) begin
                     w_state_nx = DATA;
                     w_s_cnt_nx = '0;
                     w_n_cnt_nx = '0;
                  end else begin
                     w_state_nx = IDLE;
                  end
               end else begin
                  w_s_cnt_nx = r_s_cnt + 1'b1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (r_s_cnt == DATA_LAST) begin
                  w_s_cnt_nx = '0;
                  w_shift_nx = {r_rx_s, r_shift[DBIT-1:1]};
                  if (r_n_cnt == N_LAST) begin
                     w_state_nx = STOP;
                  end else begin
                     w_n_cnt_nx = r_n_cnt + 1'b1;
                  end
               end else begin
                  w_s_cnt_nx = r_s_cnt + 1'b1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (r_s_cnt == STOP_LAST) begin
                  w_dout_nx  = r_shift;
                  w_ferr_nx  = ~r_rx_s;
                  w_done_nx  = 1'b1;
                  w_state_nx = IDLE;
               end else begin
                  w_s_cnt_nx = r_s_cnt + 1'b1;
               end
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   assign rx_dout      = r_dout;
   assign rx_done_tick = r_done;
   assign frame_err    = r_ferr;

endmodule
